// File: rtl/mrge_pkg.sv
// Shared types and constants for the mrge_sort_seq merge sorter.
package mrge_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MERGE = 2'd1,
    DONE  = 2'd2
  } mrge_state_t;

  localparam logic MRGE_ASC  = 1'b0;
  localparam logic MRGE_DESC = 1'b1;

endpackage

// File: rtl/mrge_cmp_sel.sv
// Merge selector: decides whether the left run supplies the next element.
// Ties go left, which keeps the merge stable in both directions.
module mrge_cmp_sel
  import mrge_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [W-1:0] i_left,
  input  logic [W-1:0] i_right,
  input  logic         i_left_empty,
  input  logic         i_right_empty,
  input  logic         i_desc,
  output logic         o_take_left
);

  always_comb begin
    o_take_left = 1'b1;
    if (i_right_empty)
      o_take_left = 1'b1;
    else if (i_left_empty)
      o_take_left = 1'b0;
    else if (i_desc == MRGE_ASC)
      o_take_left = (i_left <= i_right);
    else
      o_take_left = (i_left >= i_right);
  end

endmodule

// File: rtl/mrge_sort_seq.sv
// Iterative bottom-up merge sorter, one element written per cycle.
// MRGE_SORT_INDEX_EN adds out_index carrying each element's original position.
module mrge_sort_seq
  import mrge_pkg::*;
#(
  parameter int N = 5,
  parameter int W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_desc,
  input  logic [N*W-1:0]          in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [N*W-1:0]          out_data,
  output logic                    busy
`ifdef MRGE_SORT_INDEX_EN
  ,
  output logic [N*$clog2(N)-1:0]  out_index
`endif
);

  localparam int PW = $clog2(N + 1);
  localparam int WW = $clog2(N) + 1;
  localparam int IW = $clog2(N);
  localparam int EW = PW + 2;

  mrge_state_t     r_state;
  logic [W-1:0]    r_buf [2][N];
  logic            r_src;
  logic            r_desc;
  logic [PW-1:0]   r_i, r_j, r_k, r_base;
  logic [WW-1:0]   r_width;
  logic            r_in_ready, r_out_valid, r_busy;
  logic [N*W-1:0]  r_out_data;

  logic [EW-1:0]   w_lend, w_rend, w_jnx, w_pass_j;
  logic [WW-1:0]   w_width_nx;
  logic [IW-1:0]   w_i_idx, w_j_idx, w_k_idx;
  logic            w_left_empty, w_right_empty, w_take_left;
  logic            w_pair_done, w_pass_done;
  logic [W-1:0]    w_left, w_right, w_sel;
  logic [W-1:0]    w_load [N];
  logic [N*W-1:0]  w_final;

  always_comb begin
    w_lend = EW'(r_base) + EW'(r_width);
    if (w_lend > EW'(N)) w_lend = EW'(N);
    w_rend = EW'(r_base) + (EW'(r_width) << 1);
    // Next pair's right start is clamped to N so it always fits a pointer.
    w_jnx = w_rend + EW'(r_width);
    if (w_jnx > EW'(N)) w_jnx = EW'(N);
    if (w_rend > EW'(N)) w_rend = EW'(N);
    w_width_nx = r_width << 1;
    w_pass_j   = EW'(w_width_nx);
    if (w_pass_j > EW'(N)) w_pass_j = EW'(N);
    w_left_empty  = (EW'(r_i) >= w_lend);
    w_right_empty = (EW'(r_j) >= w_rend);
    w_pair_done   = (EW'(r_k) + EW'(1) == w_rend);
    w_pass_done   = (EW'(r_k) + EW'(1) == EW'(N));
    w_i_idx = (EW'(r_i) < EW'(N)) ? IW'(r_i) : '0;
    w_j_idx = (EW'(r_j) < EW'(N)) ? IW'(r_j) : '0;
    w_k_idx = (EW'(r_k) < EW'(N)) ? IW'(r_k) : '0;
  end

  assign w_left  = r_buf[r_src][w_i_idx];
  assign w_right = r_buf[r_src][w_j_idx];
  assign w_sel   = w_take_left ? w_left : w_right;

  mrge_cmp_sel #(.W(W)) u_cmp (
    .i_left        (w_left),
    .i_right       (w_right),
    .i_left_empty  (w_left_empty),
    .i_right_empty (w_right_empty),
    .i_desc        (r_desc),
    .o_take_left   (w_take_left)
  );

  // Final vector includes the element being written on the last merge edge.
  always_comb begin
    w_final = '0;
    for (int unsigned e = 0; e < N; e++) begin
      w_load[e] = in_data[e*W +: W];
      w_final[e*W +: W] = (w_k_idx == IW'(e)) ? w_sel : r_buf[~r_src][IW'(e)];
    end
  end

`ifdef MRGE_SORT_INDEX_EN
  logic [IW-1:0]   r_idx [2][N];
  logic [IW-1:0]   w_idx_init [N];
  logic [IW-1:0]   w_idx_sel;
  logic [N*IW-1:0] w_idx_final;
  logic [N*IW-1:0] r_out_index;

  assign w_idx_sel = w_take_left ? r_idx[r_src][w_i_idx] : r_idx[r_src][w_j_idx];

  always_comb begin
    w_idx_final = '0;
    for (int unsigned e = 0; e < N; e++) begin
      w_idx_init[e] = IW'(e);
      w_idx_final[e*IW +: IW] = (w_k_idx == IW'(e)) ? w_idx_sel : r_idx[~r_src][IW'(e)];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx[0]    <= '{default: '0};
      r_idx[1]    <= '{default: '0};
      r_out_index <= '0;
    end else if (r_state == IDLE && in_valid) begin
      r_idx[0] <= w_idx_init;
    end else if (r_state == MERGE) begin
      r_idx[~r_src][w_k_idx] <= w_idx_sel;
      if (w_pass_done && EW'(w_width_nx) >= EW'(N))
        r_out_index <= w_idx_final;
    end
  end

  assign out_index = r_out_index;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_buf[0]    <= '{default: '0};
      r_buf[1]    <= '{default: '0};
      r_src       <= 1'b0;
      r_desc      <= MRGE_ASC;
      r_i         <= '0;
      r_j         <= '0;
      r_k         <= '0;
      r_base      <= '0;
      r_width     <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_out_data  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_buf[0]   <= w_load;
            r_src      <= 1'b0;
            r_desc     <= in_desc;
            r_width    <= WW'(1);
            r_base     <= '0;
            r_i        <= '0;
            r_j        <= PW'(1);
            r_k        <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= MERGE;
          end
        end
        MERGE: begin
          r_buf[~r_src][w_k_idx] <= w_sel;
          r_k <= r_k + PW'(1);
          if (w_take_left) r_i <= r_i + PW'(1);
          else             r_j <= r_j + PW'(1);
          if (w_pass_done) begin
            r_src   <= ~r_src;
            r_width <= w_width_nx;
            r_base  <= '0;
            r_i     <= '0;
            r_j     <= PW'(w_pass_j);
            r_k     <= '0;
            if (EW'(w_width_nx) >= EW'(N)) begin
              r_out_data  <= w_final;
              r_out_valid <= 1'b1;
              r_state     <= DONE;
            end
          end else if (w_pair_done) begin
            r_base <= PW'(w_rend);
            r_i    <= PW'(w_rend);
            r_j    <= PW'(w_jnx);
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign busy      = r_busy;

endmodule

// File: tb/tb_mrge_sort_seq.sv
// Directed self-checking bench for mrge_sort_seq (N=5/W=16, N=8/W=8, N=2/W=16).
module tb_mrge_sort_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic        v5 = 0, r5, d5 = 0, ov5, ordy5 = 0, busy5;
  logic [79:0] din5 = '0, dout5;
  logic        v8 = 0, r8, d8 = 0, ov8, ordy8 = 0, busy8;
  logic [63:0] din8 = '0, dout8;
  logic        v2 = 0, r2, d2 = 0, ov2, ordy2 = 0, busy2;
  logic [31:0] din2 = '0, dout2;
`ifdef MRGE_SORT_INDEX_EN
  logic [14:0] idx5;
  logic [23:0] idx8;
  logic [1:0]  idx2;
`endif

  mrge_sort_seq #(.N(5), .W(16)) u5 (
    .clk(clk), .rst_n(rst_n), .in_valid(v5), .in_ready(r5), .in_desc(d5),
    .in_data(din5), .out_valid(ov5), .out_ready(ordy5), .out_data(dout5), .busy(busy5)
`ifdef MRGE_SORT_INDEX_EN
    , .out_index(idx5)
`endif
  );

  mrge_sort_seq #(.N(8), .W(8)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(r8), .in_desc(d8),
    .in_data(din8), .out_valid(ov8), .out_ready(ordy8), .out_data(dout8), .busy(busy8)
`ifdef MRGE_SORT_INDEX_EN
    , .out_index(idx8)
`endif
  );

  mrge_sort_seq #(.N(2), .W(16)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(r2), .in_desc(d2),
    .in_data(din2), .out_valid(ov2), .out_ready(ordy2), .out_data(dout2), .busy(busy2)
`ifdef MRGE_SORT_INDEX_EN
    , .out_index(idx2)
`endif
  );

  // Drives one vector into u5 and waits (bounded) for out_valid.
  task automatic run5(input logic [79:0] d, input logic desc,
                      output logic [79:0] res, output int lat, output bit busy_ok);
    busy_ok = 1'b1;
    @(posedge clk); #1;
    v5 = 1'b1; din5 = d; d5 = desc;
    @(posedge clk); #1;
    v5 = 1'b0;
    lat = 0;
    while (ov5 !== 1'b1 && lat < 200) begin
      if (busy5 !== 1'b1) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    if (busy5 !== 1'b1) busy_ok = 1'b0;
    res = dout5;
  endtask

  task automatic pop5();
    ordy5 = 1'b1;
    @(posedge clk); #1;
    ordy5 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_checks++; if (r5 !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", r5); end
    n_checks++; if (ov5 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", ov5); end
    n_checks++; if (busy5 !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy5); end
    n_checks++; if (dout5 !== 80'd0) begin n_fail++; $display("FAIL reset_out_data got %h want 0", dout5); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_asc();
    logic [79:0] res; int lat; bit bok;
    run5({16'd7, 16'd1, 16'd9, 16'd3, 16'd5}, 1'b0, res, lat, bok);
    n_checks++; if (res !== {16'd9, 16'd7, 16'd5, 16'd3, 16'd1}) begin n_fail++; $display("FAIL asc_data got %h want 00090007000500030001", res); end
    n_checks++; if (lat != 15) begin n_fail++; $display("FAIL asc_latency got %0d want 15", lat); end
    n_checks++; if (!bok) begin n_fail++; $display("FAIL asc_busy got low want high"); end
    pop5();
  endtask

  task automatic test_desc();
    logic [79:0] res; int lat; bit bok;
    run5({16'd7, 16'd1, 16'd9, 16'd3, 16'd5}, 1'b1, res, lat, bok);
    n_checks++; if (res !== {16'd1, 16'd3, 16'd5, 16'd7, 16'd9}) begin n_fail++; $display("FAIL desc_data got %h want 00010003000500070009", res); end
    n_checks++; if (lat != 15) begin n_fail++; $display("FAIL desc_latency got %0d want 15", lat); end
    pop5();
  endtask

  task automatic test_stable_ties();
    logic [79:0] res; int lat; bit bok;
    run5({16'd0, 16'd4, 16'd2, 16'd4, 16'd4}, 1'b0, res, lat, bok);
    n_checks++; if (res !== {16'd4, 16'd4, 16'd4, 16'd2, 16'd0}) begin n_fail++; $display("FAIL ties_data got %h want 00040004000400020000", res); end
`ifdef MRGE_SORT_INDEX_EN
    n_checks++; if (idx5 !== {3'd3, 3'd1, 3'd0, 3'd2, 3'd4}) begin n_fail++; $display("FAIL ties_index got %h want %h", idx5, {3'd3, 3'd1, 3'd0, 3'd2, 3'd4}); end
`endif
    pop5();
  endtask

  task automatic test_backpressure();
    logic [79:0] res; int lat; bit bok;
    logic [79:0] want;
    want = {16'd300, 16'd200, 16'd100, 16'd20, 16'd10};
    run5({16'd20, 16'd300, 16'd10, 16'd200, 16'd100}, 1'b0, res, lat, bok);
    n_checks++; if (res !== want) begin n_fail++; $display("FAIL bp_data got %h want %h", res, want); end
    for (int c = 0; c < 10; c++) begin
      v5 = 1'b1; din5 = {5{16'(c * 1111 + 7)}};
      @(posedge clk); #1;
      n_checks++; if (dout5 !== want) begin n_fail++; $display("FAIL bp_hold_data cycle %0d got %h want %h", c, dout5, want); end
      n_checks++; if (r5 !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready cycle %0d got %b want 0", c, r5); end
      n_checks++; if (ov5 !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid cycle %0d got %b want 1", c, ov5); end
    end
    v5 = 1'b0;
    n_checks++; if (r5 !== 1'b0) begin n_fail++; $display("FAIL bp_ready_before_pop got %b want 0", r5); end
    pop5();
    n_checks++; if (ov5 !== 1'b0) begin n_fail++; $display("FAIL bp_valid_after_pop got %b want 0", ov5); end
    n_checks++; if (r5 !== 1'b1) begin n_fail++; $display("FAIL bp_ready_after_pop got %b want 1", r5); end
    n_checks++; if (busy5 !== 1'b0) begin n_fail++; $display("FAIL bp_busy_after_pop got %b want 0", busy5); end
  endtask

  task automatic test_reset_mid_sort();
    logic [79:0] res; int lat; bit bok;
    @(posedge clk); #1;
    v5 = 1'b1; din5 = {16'd7, 16'd1, 16'd9, 16'd3, 16'd5}; d5 = 1'b0;
    @(posedge clk); #1;
    v5 = 1'b0;
    repeat (6) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++; if (ov5 !== 1'b0) begin n_fail++; $display("FAIL rst_mid_out_valid got %b want 0", ov5); end
    n_checks++; if (dout5 !== 80'd0) begin n_fail++; $display("FAIL rst_mid_out_data got %h want 0", dout5); end
    n_checks++; if (r5 !== 1'b1) begin n_fail++; $display("FAIL rst_mid_in_ready got %b want 1", r5); end
    n_checks++; if (busy5 !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy got %b want 0", busy5); end
    @(negedge clk);
    rst_n = 1'b1;
    run5({16'h7FFF, 16'h0001, 16'h8000, 16'h0000, 16'hFFFF}, 1'b0, res, lat, bok);
    n_checks++; if (res !== {16'hFFFF, 16'h8000, 16'h7FFF, 16'h0001, 16'h0000}) begin n_fail++; $display("FAIL rst_mid_resort got %h want FFFF80007FFF00010000", res); end
    n_checks++; if (lat != 15) begin n_fail++; $display("FAIL rst_mid_latency got %0d want 15", lat); end
    pop5();
  endtask

  task automatic test_n8();
    int lat;
    @(posedge clk); #1;
    v8 = 1'b1; din8 = 64'h0001020304050607; d8 = 1'b0;
    @(posedge clk); #1;
    v8 = 1'b0;
    lat = 0;
    while (ov8 !== 1'b1 && lat < 200) begin @(posedge clk); #1; lat++; end
    n_checks++; if (dout8 !== 64'h0706050403020100) begin n_fail++; $display("FAIL n8_data got %h want 0706050403020100", dout8); end
    n_checks++; if (lat != 24) begin n_fail++; $display("FAIL n8_latency got %0d want 24", lat); end
    ordy8 = 1'b1; @(posedge clk); #1; ordy8 = 1'b0;
  endtask

  task automatic test_n2();
    int lat;
    @(posedge clk); #1;
    v2 = 1'b1; din2 = {16'd1, 16'd2}; d2 = 1'b0;
    @(posedge clk); #1;
    v2 = 1'b0;
    lat = 0;
    while (ov2 !== 1'b1 && lat < 200) begin @(posedge clk); #1; lat++; end
    n_checks++; if (dout2 !== {16'd2, 16'd1}) begin n_fail++; $display("FAIL n2_data got %h want 00020001", dout2); end
    n_checks++; if (lat != 2) begin n_fail++; $display("FAIL n2_latency got %0d want 2", lat); end
    ordy2 = 1'b1; @(posedge clk); #1; ordy2 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_asc();
    test_desc();
    test_stable_ties();
    test_backpressure();
    test_reset_mid_sort();
    test_n8();
    test_n2();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mrge_sort_seq.md
Name: mrge_sort_seq

Overview:
- Parametrised, iterative bottom-up merge sorter; successor to the fixed 5×16-bit, mode-stepped sorter.
- Accepts a vector of N unsigned W-bit elements through a valid/ready handshake and sorts it internally, ascending or descending.
- Presents the sorted vector through a valid/ready output handshake.
- Sits between the data-capture stage and downstream consumers; sequences itself, so no external mode stepping is needed.

Parameters:
- N, 5, element count per vector; legal range N >= 2.
- W, 16, element width in bits, unsigned.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input vector valid.
- in_ready  out  1  block can accept a vector.
- in_desc  in  1  sort direction, sampled at acceptance; 0 = ascending, 1 = descending.
- in_data  in  N*W  input vector; element e at bits [e*W +: W].
- out_valid  out  1  sorted vector valid.
- out_ready  in  1  consumer accepts the sorted vector.
- out_data  out  N*W  sorted vector, same packing; element 0 is first in sort order.
- busy  out  1  high in LOAD-to-DONE states (MERGE, DONE).

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; in_ready = 1; out_valid = 0; busy = 0.
  - out_data = 0; internal buffers and pointers cleared.
  - A sort in progress is abandoned; no partial output is ever presented.
- States:
  - IDLE: in_ready = 1. On in_valid && in_ready: load in_data into buffer A, latch in_desc, width = 1, base = 0, go to MERGE.
  - MERGE: exactly one element is written to the destination buffer per cycle.
  - DONE: out_valid = 1 and out_data is driven from the final buffer.
- Pass structure:
  - Run pairs are left = [base, base+width) and right = [base+width, min(base+2*width, N)).
  - Pointers i (left), j (right), k (destination).
- Per-cycle merge rule:
  - If both runs are non-empty, take the left element when it is "not after" the right element; otherwise take the right element.
  - "Not after" means left <= right when ascending, left >= right when descending. Ties take left, so the sort is stable.
  - If one run is exhausted, copy from the other.
  - If base+width >= N (right run empty), the left run is copied unchanged.
- Pass boundaries:
  - After run-pair completion, base += 2*width.
  - After N writes the pass is complete: source and destination buffers swap roles, width doubles, base = 0.
  - When width >= N after a swap, go to DONE.
- Latency:
  - Pass count P = ceil(log2 N).
  - out_valid rises exactly N*P cycles after the accepting edge: N=5 gives 15, N=8 gives 24, N=2 gives 2.
- Output handshake:
  - DONE holds out_data stable until out_valid && out_ready.
  - On that handshake, go to IDLE and set out_valid = 0 on the same edge.
  - in_ready rises the following cycle; there is no accept in DONE.
- Arithmetic and widths:
  - Comparisons are unsigned, W bits.
  - Pointers are $clog2(N+1) bits; the width register is $clog2(N)+1 bits. This prevents overflow at width doubling for non-power-of-two N.
- Port sampling rules:
  - in_valid is ignored outside IDLE.
  - in_data and in_desc are sampled only on acceptance.
  - out_ready is ignored outside DONE.

Optional Feature:
- Macro: MRGE_SORT_INDEX_EN.
- Defined:
  - Adds output out_index, width N*$clog2(N), with the same packing as out_data.
  - Entry e is the original input position of out_data element e.
  - Indices travel with the data through every merge, so stability is observable.
  - out_index resets to 0.
- Undefined: no port, no index storage; behaviour is otherwise identical.

Decomposition:
- Package mrge_pkg holds:
  - the state typedef (IDLE, MERGE, DONE);
  - the direction constants MRGE_ASC = 0 and MRGE_DESC = 1.
- One sub-module, mrge_cmp_sel, is natural. It is combinational:
  - inputs: left element, right element, exhausted flags, direction;
  - output: take_left;
  - it encapsulates the tie and direction rule.
- All pass, pointer and buffer sequencing stays in mrge_sort_seq.

Test Plan:
1. N=5, W=16, ascending, in {5,3,9,1,7} -> out {1,3,5,7,9}; out_valid exactly 15 cycles after the accepting edge; busy high throughout.
2. Same input with in_desc=1 -> out {9,7,5,3,1}; identical latency.
3. MRGE_SORT_INDEX_EN defined, ascending, in {4,4,2,4,0} -> out {0,2,4,4,4}, out_index {4,2,0,1,3} (stable tie order).
4. Backpressure: hold out_ready=0 for 10 cycles in DONE with in_valid=1 and changing in_data -> out_data stable, in_ready=0, no accept; out_ready=1 -> IDLE; in_ready=1 the next cycle.
5. Reset mid-sort: drop rst_n at merge cycle 7 -> out_valid=0, out_data=0, in_ready=1 immediately; after release, sorting {0xFFFF,0x0000,0x8000,0x0001,0x7FFF} -> {0x0000,0x0001,0x7FFF,0x8000,0xFFFF}.
6. N=8, W=8, in {7,6,5,4,3,2,1,0} ascending -> out {0..7}, latency 24; N=2 in {2,1} -> {1,2}, latency 2.
